// File: rtl/pll_rst_ctrl_if.sv
// Signal bundle between the PLL reset sequencer, the PLL wrapper and the
// downstream reset/status consumers.
interface pll_rst_ctrl_if;
  logic       pll_lock;
  logic       pll_rst;
  logic       rst_n_out;
  logic       lock_ok;
  logic [7:0] retry_cnt;
  logic [7:0] lost_cnt;

  modport master (
    input  pll_lock,
    output pll_rst, rst_n_out, lock_ok, retry_cnt, lost_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_rst, rst_n_out, lock_ok, retry_cnt, lost_cnt
  );
endinterface

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, retries on lock timeout and
// releases the downstream reset only after lock has been stable long enough.
module pll_rst_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  pll_rst_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    RESET_PLL = 4'b0001,
    WAIT_LOCK = 4'b0010,
    STABLE    = 4'b0100,
    RUN       = 4'b1000
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             lock_s_q, lock_s_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= RESET_PLL;
      cnt_q    <= '0;
      sync_q   <= 1'b0;
      lock_s_q <= 1'b0;
      retry_q  <= '0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      lock_s_q <= lock_s_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    lost_d   = lost_q;
    sync_d   = bus.pll_lock;
    lock_s_d = sync_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a simultaneous timeout.
        if (lock_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = RESET_PLL;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end
      STABLE: begin
        if (!lock_s_q)                state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = RESET_PLL;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    // Counter restarts on every transition and idles at zero while running.
    if (state_d != state_q || state_q == RUN) cnt_d = '0;
    else                                      cnt_d = cnt_q + CNT_W'(1);
  end

  assign bus.pll_rst   = state_q[0];
  assign bus.rst_n_out = state_q[3];
  assign bus.lock_ok   = state_q[3];
  assign bus.retry_cnt = retry_q;
  assign bus.lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: expectations are queued as stimulus is
// applied and popped when the corresponding DUT behaviour is measured.
module tb_pll_rst_ctrl;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   failures;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t sb[$];

  pll_rst_ctrl_if bus ();

  pll_rst_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (64),
    .STABLE_CYCLES(16),
    .CNT_W        (16)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic push(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Steps clock edges until the selected output equals val; n = -1 on timeout.
  task automatic count_until(input int sel, input logic val, input int limit, output int n);
    logic s;
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      s = (sel == 0) ? bus.pll_rst : bus.rst_n_out;
      if (s === val) begin
        n = k;
        break;
      end
    end
  endtask

  function automatic int status_vec();
    return int'({bus.pll_rst, bus.rst_n_out, bus.lock_ok, bus.retry_cnt, bus.lost_cnt});
  endfunction

  task automatic test_reset();
    int   got[$];
    exp_t e;
    sys_rst_n    = 1'b0;
    bus.pll_lock = 1'b0;
    push("reset_outputs", 1 << 18);
    step();
    step();
    got.push_back(status_vec());
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  task automatic test_normal_lock();
    int   got[$];
    int   n;
    exp_t e;
    push("nl_pll_rst_high", 4);
    push("nl_lock_latency", 18);
    push("nl_lock_ok", 1);
    push("nl_retry", 0);
    sys_rst_n = 1'b1;
    count_until(0, 1'b0, 100, n);
    got.push_back(n);
    repeat (20) step();
    bus.pll_lock = 1'b1;
    count_until(1, 1'b1, 100, n);
    got.push_back(n < 0 ? n : n - 1);
    got.push_back(int'(bus.lock_ok));
    got.push_back(int'(bus.retry_cnt));
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  task automatic test_never_lock();
    int   got[$];
    exp_t e;
    logic hist [0:300];
    int   idx, h1, l1, h2, seen;
    sys_rst_n    = 1'b0;
    bus.pll_lock = 1'b0;
    step();
    push("nv_high", 4);
    push("nv_low", 64);
    push("nv_high2", 4);
    push("nv_retry_271", 3);
    push("nv_retry_272", 4);
    push("nv_retry_300", 4);
    push("nv_rstn_seen", 0);
    sys_rst_n = 1'b1;
    hist[0]   = bus.pll_rst;
    seen      = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      hist[k] = bus.pll_rst;
      if (bus.rst_n_out !== 1'b0) seen = 1;
      if (k == 271 || k == 272 || k == 300) got.push_back(int'(bus.retry_cnt));
    end
    idx = 0; h1 = 0; l1 = 0; h2 = 0;
    while (idx <= 300 && hist[idx] === 1'b1) begin h1++; idx++; end
    while (idx <= 300 && hist[idx] === 1'b0) begin l1++; idx++; end
    while (idx <= 300 && hist[idx] === 1'b1) begin h2++; idx++; end
    got.push_front(h2);
    got.push_front(l1);
    got.push_front(h1);
    got.push_back(seen);
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  task automatic test_glitch_stable();
    int   got[$];
    int   n;
    exp_t e;
    sys_rst_n    = 1'b0;
    bus.pll_lock = 1'b0;
    step();
    push("gl_pll_rst_high", 4);
    push("gl_run_latency", 18);
    push("gl_retry", 0);
    push("gl_lost", 0);
    sys_rst_n = 1'b1;
    count_until(0, 1'b0, 100, n);
    got.push_back(n);
    bus.pll_lock = 1'b1;
    repeat (8) step();
    bus.pll_lock = 1'b0;
    step();
    bus.pll_lock = 1'b1;
    count_until(1, 1'b1, 100, n);
    got.push_back(n < 0 ? n : n - 1);
    got.push_back(int'(bus.retry_cnt));
    got.push_back(int'(bus.lost_cnt));
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  task automatic test_loss_run();
    int   got[$];
    int   n;
    exp_t e;
    push("ls_loss_latency", 2);
    push("ls_pll_rst", 1);
    push("ls_lock_ok", 0);
    push("ls_lost", 1);
    push("ls_pll_rst_high", 4);
    push("ls_relock_latency", 18);
    push("ls_lost_after", 1);
    bus.pll_lock = 1'b0;
    count_until(1, 1'b0, 20, n);
    got.push_back(n < 0 ? n : n - 1);
    got.push_back(int'(bus.pll_rst));
    got.push_back(int'(bus.lock_ok));
    got.push_back(int'(bus.lost_cnt));
    count_until(0, 1'b0, 20, n);
    got.push_back(n);
    bus.pll_lock = 1'b1;
    count_until(1, 1'b1, 100, n);
    got.push_back(n < 0 ? n : n - 1);
    got.push_back(int'(bus.lost_cnt));
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int   got[$];
    exp_t e;
    push("mr_in_run", 1);
    push("mr_async_outputs", 1 << 18);
    got.push_back(int'(bus.rst_n_out));
    #3;
    sys_rst_n = 1'b0;
    #1;
    got.push_back(status_vec());
    @(negedge sys_clk);
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  task automatic test_saturation();
    int   got[$];
    int   n, tmo;
    exp_t e;
    sys_rst_n    = 1'b0;
    bus.pll_lock = 1'b0;
    step();
    push("sat_lost_254", 254);
    push("sat_lost_255", 255);
    push("sat_lost_260", 255);
    push("sat_wait_timeouts", 0);
    push("sat_lost_cleared", 0);
    push("sat_retry_254", 254);
    push("sat_retry_255", 255);
    push("sat_retry_260", 255);
    sys_rst_n = 1'b1;
    tmo       = 0;
    for (int i = 1; i <= 260; i++) begin
      bus.pll_lock = 1'b1;
      count_until(1, 1'b1, 200, n);
      if (n < 0) tmo++;
      bus.pll_lock = 1'b0;
      count_until(1, 1'b0, 20, n);
      if (n < 0) tmo++;
      if (i == 254 || i == 255 || i == 260) got.push_back(int'(bus.lost_cnt));
    end
    got.push_back(tmo);
    sys_rst_n = 1'b0;
    step();
    got.push_back(int'(bus.lost_cnt));
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 260 * 68; k++) begin
      step();
      if (k == 254 * 68 || k == 255 * 68 || k == 260 * 68) got.push_back(int'(bus.retry_cnt));
    end
    foreach (got[i]) begin
      e = sb.pop_front();
      checks++;
      if (got[i] !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, got[i], e.val);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    sys_rst_n    = 1'b0;
    bus.pll_lock = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_normal_lock();
    test_never_lock();
    test_glitch_stable();
    test_loss_run();
    test_reset_mid_run();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_rst_ctrl.md
# pll_rst_ctrl

Reset sequencer directly downstream of the board PLL wrapper. It consumes the PLL's asynchronous `pll_lock` and drives the PLL `RST` pin. It retries the PLL when lock is not reached within a timeout. It releases a clean reset to the LED datapath only after lock has been stable for a programmable time. The block runs on the 50 MHz board input clock, the same clock that feeds `clkin1`, so it keeps working while the PLL outputs are absent.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥2).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before retry (1 ms at 50 MHz, ≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥2).
- `CNT_W`, 16: width of the shared phase counter; must hold max(parameter)−1.

- `sys_clk`  in  1  50 MHz board clock, same source as PLL `clkin1`.
- `sys_rst_n`  in  1  Reset. One clock; reset is asynchronous and active-low.
- `pll_lock`  in  1  PLL LOCK; asynchronous to `sys_clk`.
- `pll_rst`  out  1  To PLL `RST`; active-high.
- `rst_n_out`  out  1  Active-low reset for downstream logic; high only in RUN.
- `lock_ok`  out  1  High only in RUN.
- `retry_cnt`  out  8  Saturating count of WAIT_LOCK timeouts.
- `lost_cnt`  out  8  Saturating count of lock losses while in RUN.

## Operation
- `pll_lock` passes through a 2-FF synchronizer; `lock_s` is the second flop. The FSM uses only `lock_s`.
- FSM is one-hot with states RESET_PLL, WAIT_LOCK, STABLE and RUN.
- `pll_rst`, `rst_n_out` and `lock_ok` are taken directly from state flops, so they are glitch-free and have no combinational decode.
- One counter `cnt` (CNT_W bits) is cleared on every state change.
- RESET_PLL:
  - `pll_rst`=1.
  - `cnt` increments each cycle.
  - At `cnt`==RST_CYCLES−1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `cnt` increments each cycle.
  - If `lock_s`=1, go to STABLE.
  - Else, at `cnt`==LOCK_TIMEOUT−1, go to RESET_PLL and increment `retry_cnt` (saturating at 255).
  - If `lock_s`=1 and terminal count occur in the same cycle, lock wins.
- STABLE:
  - `cnt` increments each cycle.
  - If `lock_s`=0, return to WAIT_LOCK. The timeout restarts from 0, and this is not counted as a retry.
  - Else, at `cnt`==STABLE_CYCLES−1, go to RUN.
  - If `lock_s` drops and terminal count occur in the same cycle, the drop wins.
- RUN:
  - `rst_n_out`=1 and `lock_ok`=1.
  - If `lock_s`=0, go to RESET_PLL and increment `lost_cnt` (saturating at 255).
- Counters `retry_cnt` and `lost_cnt` clear only on `sys_rst_n`.

## Timing
- Reset values while `sys_rst_n`=0:
  - state=RESET_PLL, `cnt`=0, both sync flops=0.
  - `pll_rst`=1, `rst_n_out`=0, `lock_ok`=0.
  - `retry_cnt`=0, `lost_cnt`=0.
- Reset assertion is asynchronous:
  - `rst_n_out` falls and `pll_rst` rises immediately, even mid-RUN.
  - Deassertion takes effect on the first `sys_clk` edge after release.
- After `sys_rst_n` release, `pll_rst` stays high for exactly RST_CYCLES rising edges, then falls.
- Lock latency, with `pll_lock` first sampled high at edge t:
  - `lock_s`=1 after edge t+1.
  - State is STABLE after edge t+2.
  - RUN, with `rst_n_out`=1, after edge t+2+STABLE_CYCLES.
- Loss latency:
  - `pll_lock` sampled low at edge t gives RUN→RESET_PLL at edge t+2.
  - At that edge `rst_n_out`=0, `pll_rst`=1 and `lost_cnt` increments.
- Retry period with lock never achieved: RST_CYCLES+LOCK_TIMEOUT cycles per retry.
- A `pll_lock` glitch of at least one sampled cycle is acted on; there is no further filtering beyond the synchronizer.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16.

1. **Normal lock.** Release reset; raise `pll_lock` 20 cycles after `pll_rst` falls → `pll_rst` was high 4 cycles; `rst_n_out` and `lock_ok` rise 18 cycles after the first high sample; `retry_cnt`=0.
2. **Never lock.** Hold `pll_lock`=0 for 300 cycles → `pll_rst` pulses 4 high / 64 low, repeating; `retry_cnt`=4 after 4×68 cycles; `rst_n_out` stays 0.
3. **Glitch in STABLE.** `pll_lock` high, then low for 1 cycle 8 cycles later, then high → return to WAIT_LOCK with no retry counted; RUN is reached 18 cycles after the final rise.
4. **Loss in RUN.** Drop `pll_lock` while in RUN → 2 cycles later `rst_n_out`=0, `pll_rst`=1 for 4 cycles, `lost_cnt`=1; relock completes normally.
5. **Reset mid-RUN.** Assert `sys_rst_n`=0 asynchronously between edges → `rst_n_out`=0 and `pll_rst`=1 immediately; both counters read 0.
6. **Saturation.** Force 260 lock losses → `lost_cnt` holds at 255; `retry_cnt` behaves the same way under 260 timeouts.
